// File: rtl/message_unpack_pkg.sv
// Shared constants for the SHA-1 candidate message block layout.
// The encoder side of the collider uses the same word map and error indices.
package message_unpack_pkg;

    localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
    localparam logic [31:0] LEN_WORD        = 32'd192;
    localparam int          WORDS_PER_FRAME = 16;

    // Word positions inside the 16-word frame.
    localparam logic [3:0] W_NONCE0   = 4'd0;
    localparam logic [3:0] W_NONCE1   = 4'd1;
    localparam logic [3:0] W_NONCE2   = 4'd2;
    localparam logic [3:0] W_NONCE3   = 4'd3;
    localparam logic [3:0] W_FIXED_HI = 4'd4;
    localparam logic [3:0] W_FIXED_LO = 4'd5;
    localparam logic [3:0] W_PAD      = 4'd6;
    localparam logic [3:0] W_LEN      = 4'd15;

    // Bit positions in the error vector.
    localparam int ERR_DIGIT = 0;
    localparam int ERR_SEP   = 1;
    localparam int ERR_PAD   = 2;
    localparam int ERR_LEN   = 3;
    localparam int ERR_FRAME = 4;
    localparam int ERR_W     = 5;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/message_unpack_bcd_byte_check.sv
// Checks one message byte for a valid BCD digit (upper nibble zero, value 0..9).
module bcd_byte_check (
    input  logic [7:0] data,
    output logic [3:0] digit,
    output logic       ok
);

    // The lower nibble is passed through even when the byte is not a digit.
    assign digit = data[3:0];
    assign ok    = (data[7:4] == 4'd0) && (data[3:0] <= 4'd9);

endmodule

// File: rtl/message_unpack.sv
// Streaming decoder: recovers the BCD nonce and fixed data from a 16-word
// SHA-1 message block and validates digits, separators, padding, length and
// framing.
//
// Handshakes: a word moves when rx_valid && rx_ready on a rising edge; a
// result moves when tx_valid && tx_ready on a rising edge. Both ready/valid
// outputs are registered, and the result fields only change while tx_valid=0.
module message_unpack
    import message_unpack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       rx_data,
    input  logic              rx_valid,
    input  logic              rx_last,
    output logic              rx_ready,
    output logic [59:0]       tx_nonce,
    output logic [55:0]       tx_fixed_data,
    output logic [ERR_W-1:0]  tx_error,
    output logic              tx_valid,
    input  logic              tx_ready,
    output state_t            dbg_state,
    output logic [3:0]        dbg_count
);

    state_t            state_q, state_d;
    logic              rx_ready_d, tx_valid_d;
    logic [3:0]        count_q;
    logic [ERR_W-1:0]  word_err;
    logic [3:0]        digit_v [4];
    logic [3:0]        ok_v;
    logic              rx_fire, tx_fire, at_end, final_word;

    assign rx_fire    = rx_valid && rx_ready;
    assign tx_fire    = tx_valid && tx_ready;
    assign at_end     = (count_q == 4'(WORDS_PER_FRAME - 1));
    assign final_word = rx_fire && (rx_last || at_end);

    assign dbg_state  = state_q;
    assign dbg_count  = count_q;

    // One checker per byte lane; lane 3 is the most significant byte.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        bcd_byte_check u_check (
            .data  (rx_data[8*i+7:8*i]),
            .digit (digit_v[i]),
            .ok    (ok_v[i])
        );
    end

    // State register plus the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_COLLECT;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_ready <= rx_ready_d;
            tx_valid <= tx_valid_d;
        end
    end

    // Next state: a frame ends on its last word, a result leaves on tx handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (final_word) state_d = ST_PRESENT;
            ST_PRESENT: if (tx_fire)    state_d = ST_COLLECT;
            default:                    state_d = ST_COLLECT;
        endcase
    end

    // Handshake outputs follow the state being entered so they are registered.
    always_comb begin
        rx_ready_d = (state_d == ST_COLLECT);
        tx_valid_d = (state_d == ST_PRESENT);
    end

    // Errors contributed by the word currently on rx_data, addressed by the counter.
    always_comb begin
        word_err = '0;
        case (count_q)
            W_NONCE0, W_NONCE1, W_NONCE2: word_err[ERR_DIGIT] = ~&ok_v;
            W_NONCE3: begin
                word_err[ERR_DIGIT] = ~&ok_v[3:1];
                word_err[ERR_SEP]   = (rx_data[7:0] != 8'd0);
            end
            W_FIXED_HI: word_err = '0;
            W_FIXED_LO: word_err[ERR_SEP] = (rx_data[7:0] != 8'd0);
            W_PAD:      word_err[ERR_PAD] = (rx_data != PAD_WORD);
            W_LEN:      word_err[ERR_LEN] = (rx_data != LEN_WORD);
            default:    word_err[ERR_PAD] = (rx_data != 32'd0);
        endcase
        // Early rx_last or a missing rx_last on word 15 both mean bad framing.
        word_err[ERR_FRAME] = rx_last ^ at_end;
    end

    // Field capture, word counter and sticky errors; all cleared after a result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            tx_nonce      <= '0;
            tx_fixed_data <= '0;
            tx_error      <= '0;
        end else if (tx_fire) begin
            count_q       <= '0;
            tx_nonce      <= '0;
            tx_fixed_data <= '0;
            tx_error      <= '0;
        end else if (rx_fire) begin
            count_q  <= count_q + 4'd1;
            tx_error <= tx_error | word_err;
            case (count_q)
                W_NONCE0:   tx_nonce[59:44] <= {digit_v[3], digit_v[2], digit_v[1], digit_v[0]};
                W_NONCE1:   tx_nonce[43:28] <= {digit_v[3], digit_v[2], digit_v[1], digit_v[0]};
                W_NONCE2:   tx_nonce[27:12] <= {digit_v[3], digit_v[2], digit_v[1], digit_v[0]};
                W_NONCE3:   tx_nonce[11:0]  <= {digit_v[3], digit_v[2], digit_v[1]};
                W_FIXED_HI: tx_fixed_data[55:24] <= rx_data;
                W_FIXED_LO: tx_fixed_data[23:0]  <= rx_data[31:8];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_message_unpack.sv
// Self-checking bench for message_unpack: directed layout cases plus random
// frames compared against a byte-level model of the message format.
module tb_message_unpack;
    import message_unpack_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_ready;
    logic [59:0] tx_nonce;
    logic [55:0] tx_fixed_data;
    logic [4:0]  tx_error;
    logic        tx_valid;
    logic        tx_ready;
    state_t      dbg_state;
    logic [3:0]  dbg_count;

    int total = 0;
    int bad   = 0;

    logic [31:0]  frame_w [16];
    logic [120:0] exp_q [$];
    logic [120:0] exp_cur;

    message_unpack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_last       (rx_last),
        .rx_ready      (rx_ready),
        .tx_nonce      (tx_nonce),
        .tx_fixed_data (tx_fixed_data),
        .tx_error      (tx_error),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference: walk the 15 digits and 7 fixed bytes by their position in
    // the byte stream (MSB first), treating unreceived words as absent.
    function automatic logic [120:0] model(input int n, input bit last_flag);
        logic [59:0] nz = '0;
        logic [55:0] fx = '0;
        logic [4:0]  er = '0;
        logic [7:0]  b;
        for (int d = 0; d < 15; d++) begin
            int i = 14 - d;
            if (i / 4 < n) begin
                b = frame_w[i/4][31-8*(i%4) -: 8];
                nz[4*d +: 4] = b[3:0];
                if (b > 8'd9) er[0] = 1'b1;
            end
        end
        if (n > 3 && frame_w[3][7:0] != 8'd0) er[1] = 1'b1;
        if (n > 5 && frame_w[5][7:0] != 8'd0) er[1] = 1'b1;
        for (int f = 0; f < 7; f++) begin
            int i  = 6 - f;
            int wi = 4 + i / 4;
            if (wi < n) fx[8*f +: 8] = frame_w[wi][31-8*(i%4) -: 8];
        end
        for (int k = 6; k < 15; k++)
            if (k < n && frame_w[k] != ((k == 6) ? PAD_WORD : 32'd0)) er[2] = 1'b1;
        if (n == 16 && frame_w[15] != LEN_WORD) er[3] = 1'b1;
        if (n < 16 || !last_flag) er[4] = 1'b1;
        return {er, fx, nz};
    endfunction

    task automatic set_golden();
        frame_w[0] = 32'h0000_0000;
        frame_w[1] = 32'h0000_0500;
        frame_w[2] = 32'h0908_0003;
        frame_w[3] = 32'h0006_0500;
        frame_w[4] = 32'h3569_1903;
        frame_w[5] = 32'h8010_8300;
        frame_w[6] = 32'h8000_0000;
        for (int k = 7; k < 15; k++) frame_w[k] = 32'd0;
        frame_w[15] = 32'h0000_00C0;
    endtask

    task automatic build_random();
        int idx;
        logic [7:0] b;
        for (int k = 0; k < 16; k++) frame_w[k] = 32'd0;
        frame_w[6]  = PAD_WORD;
        frame_w[15] = LEN_WORD;
        for (int i = 0; i < 15; i++) begin
            b = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            frame_w[i/4][31-8*(i%4) -: 8] = b;
        end
        frame_w[4] = $urandom;
        frame_w[5][31:8] = 24'($urandom);
        if ($urandom_range(0, 7) == 0) frame_w[3][7:0] = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 7) == 0) frame_w[5][7:0] = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(6, 14);
            frame_w[idx] = frame_w[idx] ^ (32'd1 << $urandom_range(0, 31));
        end
        if ($urandom_range(0, 9) == 0) frame_w[15] = $urandom;
    endtask

    // Driver: present words 0..n-1 with optional idle gaps; returns #1 after
    // the edge that accepted the last word.
    task automatic send_frame(input int n, input bit last_flag, input int gap_max);
        int waited;
        for (int k = 0; k < n; k++) begin
            int gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            rx_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_data  = frame_w[k];
            rx_last  = (k == n - 1) && last_flag;
            waited   = 0;
            while (rx_ready !== 1'b1 && waited < 100) begin
                @(posedge clk); #1;
                waited++;
            end
            if (rx_ready !== 1'b1) begin
                check("rx_ready_timeout", {127'd0, rx_ready}, 128'd1);
                rx_valid = 1'b0;
                rx_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = $urandom;
    endtask

    task automatic check_outputs(input string tag, input logic [120:0] e);
        check({tag, "_nonce"}, 128'(tx_nonce),      128'(e[59:0]));
        check({tag, "_fixed"}, 128'(tx_fixed_data), 128'(e[115:60]));
        check({tag, "_error"}, 128'(tx_error),      128'(e[120:116]));
    endtask

    task automatic consume(input string tag);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(tx_valid), 128'd0);
    endtask

    // One frame: scoreboard push, drive, latency and field checks, consume.
    task automatic run_frame(input string tag, input int n, input bit last_flag,
                             input int gap_max, input bit golden, input int lit_err);
        exp_q.push_back(model(n, last_flag));
        send_frame(n, last_flag, gap_max);
        check({tag, "_latency"}, 128'(tx_valid), 128'd1);
        check({tag, "_rx_ready_low"}, 128'(rx_ready), 128'd0);
        exp_cur = exp_q.pop_front();
        check_outputs(tag, exp_cur);
        if (golden) begin
            check({tag, "_gold_nonce"}, 128'(tx_nonce), 128'(60'h000000509803065));
            check({tag, "_gold_fixed"}, 128'(tx_fixed_data), 128'(56'h35691903801083));
        end
        if (lit_err >= 0) check({tag, "_lit_error"}, 128'(tx_error), 128'(lit_err));
        consume(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 32'd0;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        tx_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 128'(rx_ready), 128'd0);
        check("rst_tx_valid", 128'(tx_valid), 128'd0);
        check("rst_nonce",    128'(tx_nonce), 128'd0);
        check("rst_fixed",    128'(tx_fixed_data), 128'd0);
        check("rst_error",    128'(tx_error), 128'd0);
        check("rst_count",    128'(dbg_count), 128'd0);
        check("rst_state",    128'(dbg_state), 128'(ST_COLLECT));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rx_ready", 128'(rx_ready), 128'd1);

        // Golden frame and single-field corruptions
        set_golden();
        run_frame("golden", 16, 1'b1, 0, 1'b1, 0);
        set_golden();
        frame_w[2] = 32'h0A08_0003;
        run_frame("digit_err", 16, 1'b1, 0, 1'b0, 5'b00001);
        check("digit6_is_a", 128'(exp_cur[27:24]), 128'(4'hA));
        set_golden();
        frame_w[3] = 32'h0006_0501;
        run_frame("sep_err", 16, 1'b1, 0, 1'b0, 5'b00010);
        set_golden();
        frame_w[15] = 32'h0000_00C8;
        frame_w[9]  = 32'd1;
        run_frame("pad_len_err", 16, 1'b1, 0, 1'b0, 5'b01100);

        // Framing: early rx_last, then missing rx_last, then recovery
        set_golden();
        run_frame("early_last", 6, 1'b1, 0, 1'b0, 5'b10000);
        set_golden();
        run_frame("no_last", 16, 1'b0, 0, 1'b0, 5'b10000);
        set_golden();
        run_frame("recover", 16, 1'b1, 0, 1'b1, 0);

        // Backpressure: result held 20 cycles while the source keeps offering data
        set_golden();
        exp_q.push_back(model(16, 1'b1));
        send_frame(16, 1'b1, 0);
        exp_cur = exp_q.pop_front();
        rx_valid = 1'b1;
        rx_last  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rx_data = $urandom;
            @(posedge clk); #1;
            check("bp_rx_ready", 128'(rx_ready), 128'd0);
            check("bp_tx_valid", 128'(tx_valid), 128'd1);
            check_outputs("bp", exp_cur);
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        consume("bp");

        // Random idle gaps on the golden frame
        set_golden();
        run_frame("gaps", 16, 1'b1, 4, 1'b1, 0);

        // Reset in the middle of a frame
        set_golden();
        send_frame(9, 1'b0, 0);
        check("mid_count_before_rst", 128'(dbg_count), 128'd9);
        rst_n = 1'b0;
        #2;
        check("midrst_tx_valid", 128'(tx_valid), 128'd0);
        check("midrst_count",    128'(dbg_count), 128'd0);
        check("midrst_nonce",    128'(tx_nonce), 128'd0);
        check("midrst_rx_ready", 128'(rx_ready), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_state", 128'(dbg_state), 128'(ST_COLLECT));
        set_golden();
        run_frame("after_rst", 16, 1'b1, 0, 1'b1, 0);

        // Random frames against the model
        for (int r = 0; r < 30; r++) begin
            int  n;
            bit  lf;
            build_random();
            if ($urandom_range(0, 4) == 0) begin
                n  = $urandom_range(1, 15);
                lf = 1'b1;
            end else begin
                n  = 16;
                lf = ($urandom_range(0, 9) != 0);
            end
            run_frame("random", n, lf, $urandom_range(0, 2), 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
